// File: rtl/wishbone_arbitrator_nm.sv
// N-master to 1-slave Wishbone arbiter: fixed-priority or round-robin selection,
// grant held for a whole CYC, optional stall timeout that aborts a hung slave access.
module wishbone_arbitrator_nm #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_MASTERS-1:0]              m_we_i,
  input  logic [NUM_MASTERS-1:0]              m_cyc_i,
  input  logic [NUM_MASTERS-1:0]              m_stb_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_o,
  output logic [NUM_MASTERS-1:0]              m_ack_o,
  output logic [NUM_MASTERS-1:0]              m_err_o,
  output logic [NUM_MASTERS-1:0]              m_int_o,
  output logic                                s_we_o,
  output logic                                s_cyc_o,
  output logic                                s_stb_o,
  output logic [DATA_WIDTH/8-1:0]             s_sel_o,
  output logic [ADDR_WIDTH-1:0]               s_adr_o,
  output logic [DATA_WIDTH-1:0]               s_dat_o,
  input  logic [DATA_WIDTH-1:0]               s_dat_i,
  input  logic                                s_ack_i,
  input  logic                                s_int_i,
  output logic [NUM_MASTERS-1:0]              grant_o
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int TW = $clog2(TIMEOUT + 2);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANTED = 2'd1;
  localparam logic [1:0] ABORT   = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] gidx;
  logic [IW-1:0] ptr;
  logic [TW-1:0] cnt;
  logic [IW-1:0] win_idx;
  logic          found;
  logic          granted;
  logic          g_cyc;
  logic          g_stb;
  logic          timeout_hit;

  // Winner search; round-robin starts just after the last winner and wraps.
  always_comb begin
    int cand;
    win_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (ROUND_ROBIN != 0) begin
        cand = int'(ptr) + 1 + k;
        if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      end else begin
        cand = k;
      end
      if (!found && m_cyc_i[IW'(cand)]) begin
        found   = 1'b1;
        win_idx = IW'(cand);
      end
    end
  end

  assign granted = (state == GRANTED);
  assign g_cyc   = m_cyc_i[gidx];
  assign g_stb   = m_stb_i[gidx];

  // An ack arriving in the expiry cycle takes precedence over the abort.
  assign timeout_hit = (TIMEOUT > 0) && granted && (cnt == TW'(TIMEOUT)) && !s_ack_i;

  assign s_cyc_o = granted & g_cyc & ~timeout_hit;
  assign s_stb_o = granted & g_stb & ~timeout_hit;
  assign s_we_o  = granted & m_we_i[gidx];
  assign s_sel_o = granted ? m_sel_i[gidx*SW +: SW] : '0;
  assign s_adr_o = granted ? m_adr_i[gidx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign s_dat_o = granted ? m_dat_i[gidx*DATA_WIDTH +: DATA_WIDTH] : '0;

  assign m_dat_o = {NUM_MASTERS{s_dat_i}};
  assign m_ack_o = grant_o & {NUM_MASTERS{s_ack_i}};
  assign m_err_o = grant_o & {NUM_MASTERS{timeout_hit}};
  assign m_int_o = grant_o & {NUM_MASTERS{s_int_i}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_o <= '0;
      gidx    <= '0;
      ptr     <= IW'(NUM_MASTERS - 1);
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (found) begin
            grant_o <= NUM_MASTERS'(1) << win_idx;
            gidx    <= win_idx;
            ptr     <= win_idx;
            state   <= GRANTED;
          end
        end
        GRANTED: begin
          if (timeout_hit) begin
            grant_o <= '0;
            cnt     <= '0;
            state   <= ABORT;
          end else if (!g_cyc && !s_ack_i) begin
            grant_o <= '0;
            cnt     <= '0;
            state   <= IDLE;
          end else if (s_ack_i) begin
            cnt <= '0;
          end else if (g_stb && (cnt != TW'(TIMEOUT))) begin
            cnt <= cnt + 1'b1;
          end
        end
        ABORT: begin
          // gidx still names the aborted master; it must drop CYC first.
          if (!m_cyc_i[gidx]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_arbitrator_nm.sv
// Bench for wishbone_arbitrator_nm: a round-robin/timeout instance and a fixed-priority
// instance share stimulus and are compared each cycle against a transaction-level model.
module tb_wishbone_arbitrator_nm;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_we, m_cyc, m_stb;
  logic [N*SW-1:0] m_sel;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack, s_int;

  logic [N*DW-1:0] mdat_rr, mdat_fp;
  logic [N-1:0]    ack_rr, err_rr, int_rr, grant_rr;
  logic [N-1:0]    ack_fp, err_fp, int_fp, grant_fp;
  logic            we_rr, cyc_rr, stb_rr, we_fp, cyc_fp, stb_fp;
  logic [SW-1:0]   sel_rr, sel_fp;
  logic [AW-1:0]   adr_rr, adr_fp;
  logic [DW-1:0]   sdat_rr, sdat_fp;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per configuration: 0 = round-robin/TIMEOUT 8, 1 = fixed/no timeout.
  int own[2];
  int blk[2];
  int last[2];
  int stall[2];
  int to_c[2] = '{8, 0};
  int rr_c[2] = '{1, 0};

  always #5 clk = ~clk;

  wishbone_arbitrator_nm #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                           .ROUND_ROBIN(1), .TIMEOUT(8)) dut_rr (
    .clk(clk), .rst(rst), .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(mdat_rr),
    .m_ack_o(ack_rr), .m_err_o(err_rr), .m_int_o(int_rr),
    .s_we_o(we_rr), .s_cyc_o(cyc_rr), .s_stb_o(stb_rr), .s_sel_o(sel_rr),
    .s_adr_o(adr_rr), .s_dat_o(sdat_rr), .s_dat_i(s_dat_i), .s_ack_i(s_ack),
    .s_int_i(s_int), .grant_o(grant_rr));

  wishbone_arbitrator_nm #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                           .ROUND_ROBIN(0), .TIMEOUT(0)) dut_fp (
    .clk(clk), .rst(rst), .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(mdat_fp),
    .m_ack_o(ack_fp), .m_err_o(err_fp), .m_int_o(int_fp),
    .s_we_o(we_fp), .s_cyc_o(cyc_fp), .s_stb_o(stb_fp), .s_sel_o(sel_fp),
    .s_adr_o(adr_fp), .s_dat_o(sdat_fp), .s_dat_i(s_dat_i), .s_ack_i(s_ack),
    .s_int_i(s_int), .grant_o(grant_fp));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input int c, input string nm, input logic [N-1:0] g, ack, err, intr,
                         input logic scyc, sstb, swe, input logic [SW-1:0] ssel,
                         input logic [AW-1:0] sadr, input logic [DW-1:0] sdat,
                         input logic [N*DW-1:0] mdat);
    logic [N-1:0] e_g, e_ack, e_err, e_int;
    logic e_cyc, e_stb, e_we, hit;
    logic [SW-1:0] e_sel;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    int o;
    o = own[c];
    {e_g, e_ack, e_err, e_int, e_cyc, e_stb, e_we, hit} = '0;
    e_sel = '0; e_adr = '0; e_dat = '0;
    if (o >= 0) begin
      hit   = (to_c[c] > 0) && (stall[c] == to_c[c]) && !s_ack;
      e_g   = N'(1) << o;
      e_cyc = m_cyc[o] && !hit;
      e_stb = m_stb[o] && !hit;
      e_we  = m_we[o];
      e_sel = m_sel[o*SW +: SW];
      e_adr = m_adr[o*AW +: AW];
      e_dat = m_dat[o*DW +: DW];
      e_ack = s_ack ? e_g : '0;
      e_err = hit ? e_g : '0;
      e_int = s_int ? e_g : '0;
    end
    chk({nm, "_grant"}, 128'(g), 128'(e_g));
    chk({nm, "_m_ack"}, 128'(ack), 128'(e_ack));
    chk({nm, "_m_err"}, 128'(err), 128'(e_err));
    chk({nm, "_m_int"}, 128'(intr), 128'(e_int));
    chk({nm, "_s_cyc"}, 128'(scyc), 128'(e_cyc));
    chk({nm, "_s_stb"}, 128'(sstb), 128'(e_stb));
    chk({nm, "_s_we"}, 128'(swe), 128'(e_we));
    chk({nm, "_s_sel"}, 128'(ssel), 128'(e_sel));
    chk({nm, "_s_adr"}, 128'(sadr), 128'(e_adr));
    chk({nm, "_s_dat"}, 128'(sdat), 128'(e_dat));
    chk({nm, "_m_dat"}, 128'(mdat), {N{s_dat_i}});
  endtask

  task automatic model_update();
    for (int c = 0; c < 2; c++) begin
      int o;
      bit hit;
      o = own[c];
      if (rst) begin
        own[c] = -1; blk[c] = -1; last[c] = N - 1; stall[c] = 0;
      end else if (o >= 0) begin
        hit = (to_c[c] > 0) && (stall[c] == to_c[c]) && !s_ack;
        if (hit) begin
          blk[c] = o; own[c] = -1; stall[c] = 0;
        end else if (!m_cyc[o] && !s_ack) begin
          own[c] = -1; stall[c] = 0;
        end else if (s_ack) begin
          stall[c] = 0;
        end else if (m_stb[o] && stall[c] < to_c[c]) begin
          stall[c] = stall[c] + 1;
        end
      end else if (blk[c] >= 0) begin
        if (!m_cyc[blk[c]]) blk[c] = -1;
      end else if (m_cyc != '0) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = rr_c[c] != 0 ? (last[c] + 1 + k) % N : k;
          if (own[c] < 0 && m_cyc[idx]) own[c] = idx;
        end
        last[c] = own[c];
        stall[c] = 0;
      end
    end
  endtask

  task automatic step();
    #1;
    chk_dut(0, "rr", grant_rr, ack_rr, err_rr, int_rr, cyc_rr, stb_rr, we_rr,
            sel_rr, adr_rr, sdat_rr, mdat_rr);
    chk_dut(1, "fp", grant_fp, ack_fp, err_fp, int_fp, cyc_fp, stb_fp, we_fp,
            sel_fp, adr_fp, sdat_fp, mdat_fp);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; m_cyc = '0; m_stb = '0; s_ack = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic rand_in(input int ack_pct, input int tog_max);
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, tog_max) == 0) m_cyc[i] = ~m_cyc[i];
      m_stb[i] = m_cyc[i] & ($urandom_range(0, 3) != 0);
      m_we[i]  = 1'($urandom);
      m_sel[i*SW +: SW] = SW'($urandom);
      m_adr[i*AW +: AW] = $urandom;
      m_dat[i*DW +: DW] = $urandom;
    end
    s_dat_i = $urandom;
    s_ack   = ($urandom_range(0, 99) < ack_pct);
    s_int   = 1'($urandom);
    rst     = ($urandom_range(0, 299) == 0);
  endtask

  initial begin
    rst = 1'b1; m_we = '0; m_cyc = '0; m_stb = '0; m_sel = '0;
    m_adr = '0; m_dat = '0; s_dat_i = '0; s_ack = 1'b0; s_int = 1'b0;
    for (int i = 0; i < 2; i++) begin
      own[i] = -1; blk[i] = -1; last[i] = N - 1; stall[i] = 0;
    end
    @(negedge clk);
    do_reset();

    // Single master request, grant one cycle later, ack routing
    chk("t1_reset_grant", 128'(grant_rr), 128'(4'b0000));
    m_cyc = 4'b0001; m_stb = 4'b0001; m_adr[31:0] = 32'h0000_1000;
    step();
    chk("t1_grant", 128'(grant_rr), 128'(4'b0001));
    #1 chk("t1_adr", 128'(adr_rr), 128'(32'h0000_1000));
    s_ack = 1'b1;
    #1 chk("t1_ack", 128'(ack_rr), 128'(4'b0001));
    step();
    s_ack = 1'b0;

    // Fixed priority with one idle cycle between grants
    do_reset();
    m_cyc = 4'b1010; m_stb = 4'b1010;
    step();
    chk("t2_fp_first", 128'(grant_fp), 128'(4'b0010));
    m_cyc = 4'b1000; m_stb = 4'b1000;
    step();
    chk("t2_fp_idle", 128'(grant_fp), 128'(4'b0000));
    step();
    chk("t2_fp_second", 128'(grant_fp), 128'(4'b1000));

    // Round-robin rotation with all masters requesting
    do_reset();
    m_cyc = 4'b1111; m_stb = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      step();
      chk($sformatf("t3_rr_grant%0d", t), 128'(grant_rr), 128'(4'b0001 << (t % 4)));
      m_cyc[t % 4] = 1'b0; s_ack = 1'b1;
      step();
      s_ack = 1'b0;
      step();
      m_cyc[t % 4] = 1'b1;
    end

    // Stall timeout after 8 unacknowledged strobe cycles
    do_reset();
    m_cyc = 4'b0100; m_stb = 4'b0100;
    step();
    for (int j = 0; j < 8; j++) begin
      chk("t4_no_err_early", 128'(err_rr), 128'(4'b0000));
      step();
    end
    #1;
    chk("t4_err", 128'(err_rr), 128'(4'b0100));
    chk("t4_cyc_forced", 128'(cyc_rr), 128'(1'b0));
    step();
    chk("t4_grant_cleared", 128'(grant_rr), 128'(4'b0000));
    step();
    chk("t4_abort_holds", 128'(grant_rr), 128'(4'b0000));
    m_cyc = '0; m_stb = '0;
    step();

    // Burst is never pre-empted
    do_reset();
    m_cyc = 4'b0001; m_stb = 4'b0001;
    step();
    m_cyc = 4'b0101; m_stb = 4'b0101;
    for (int b = 0; b < 3; b++) begin
      s_ack = 1'b1;
      step();
      chk($sformatf("t5_hold%0d", b), 128'(grant_rr), 128'(4'b0001));
    end
    s_ack = 1'b0; m_cyc = 4'b0100; m_stb = 4'b0100;
    step();
    step();
    chk("t5_rr_next", 128'(grant_rr), 128'(4'b0100));
    chk("t5_fp_next", 128'(grant_fp), 128'(4'b0100));

    // Reset in the middle of a granted cycle
    do_reset();
    m_cyc = 4'b0001; m_stb = 4'b0001;
    step();
    s_ack = 1'b1; rst = 1'b1;
    step();
    #1;
    chk("t6_grant", 128'(grant_rr), 128'(4'b0000));
    chk("t6_ack", 128'(ack_rr), 128'(4'b0000));
    chk("t6_cyc", 128'(cyc_rr), 128'(1'b0));
    rst = 1'b0; s_ack = 1'b0;
    step();

    // Random traffic: busy slave, then a hung slave to exercise timeouts
    for (int i = 0; i < 1200; i++) begin
      rand_in(30, 5);
      step();
    end
    for (int i = 0; i < 800; i++) begin
      rand_in((i % 100) < 80 ? 0 : 20, 20);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
